// File: rtl/mux_pkg.sv
// Shared constants and helpers for the scanning multiplexer.
package mux_pkg;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FULL = 1'b1;

    // Bits needed to index v items (ceil(log2(v))); 0 for v <= 1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_n_comb.sv
// Purely combinational N-way indexed select; out-of-range index yields zero.
module mux_n_comb
    import mux_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned W     = 1,
    localparam int unsigned SEL_W = clog2(N)
) (
    input  logic [N*W-1:0]   w_i,
    input  logic [SEL_W-1:0] idx_i,
    output logic [W-1:0]     y_o
);

    // Compare-and-select per channel; indices N..2^SEL_W-1 match nothing.
    always_comb begin
        y_o = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (idx_i == SEL_W'(k)) begin
                y_o = w_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/mux_scan_n.sv
// N-input W-bit multiplexer with manual/scan channel selection and a
// registered valid/ready output stage.
module mux_scan_n
    import mux_pkg::*;
#(
    parameter  int unsigned N     = 8,
    parameter  int unsigned W     = 1,
    localparam int unsigned SEL_W = clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N*W-1:0]   w,
    input  logic [SEL_W-1:0] s,
    input  logic             mode,
    input  logic             en,
    output logic [W-1:0]     f,
    output logic [SEL_W-1:0] ch,
    output logic             f_valid,
    input  logic             f_ready,
    output logic             wrap,
    output logic             sel_err
);

    logic [0:0]       state_q, state_d;
    logic [W-1:0]     f_q, f_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic             wrap_q, wrap_d;
    logic             sel_err_q, sel_err_d;
    logic             mode_q;

    logic             scan_c;
    logic             load_c;
    logic [SEL_W-1:0] ptr_eff_c;
    logic [SEL_W-1:0] csel_c;
    logic             s_bad_c;
    logic [W-1:0]     mux_y_c;

    // Capture is allowed when the output slot is empty or being drained now.
    assign scan_c  = (mode == MODE_SCAN);
    assign load_c  = en && ((state_q == ST_IDLE) || f_ready);

    // Entering scan mode restarts the sweep at channel 0 in the same cycle.
    assign ptr_eff_c = (scan_c && (mode_q == MODE_MANUAL)) ? '0 : ptr_q;
    assign csel_c    = scan_c ? ptr_eff_c : s;
    assign s_bad_c   = (32'(s) >= N);

    // Out-of-range manual selects read as zero from the select network.
    mux_n_comb #(
        .N (N),
        .W (W)
    ) u_mux (
        .w_i   (w),
        .idx_i (csel_c),
        .y_o   (mux_y_c)
    );

    // Next-state for the handshake FSM, scan pointer and output payload.
    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        ch_d      = ch_q;
        wrap_d    = 1'b0;
        sel_err_d = sel_err_q;
        ptr_d     = ptr_eff_c;

        case (state_q)
            ST_IDLE: begin
                if (load_c) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (f_ready && !en) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (load_c) begin
            f_d  = mux_y_c;
            ch_d = csel_c;
            if (scan_c) begin
                wrap_d = (ptr_eff_c == SEL_W'(N - 1));
                ptr_d  = wrap_d ? '0 : ptr_eff_c + SEL_W'(1);
            end else begin
                sel_err_d = s_bad_c;
            end
        end
    end

    // State and output registers; reset drops any pending sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            f_q       <= '0;
            ch_q      <= '0;
            ptr_q     <= '0;
            wrap_q    <= 1'b0;
            sel_err_q <= 1'b0;
            mode_q    <= MODE_MANUAL;
        end else begin
            state_q   <= state_d;
            f_q       <= f_d;
            ch_q      <= ch_d;
            ptr_q     <= ptr_d;
            wrap_q    <= wrap_d;
            sel_err_q <= sel_err_d;
            mode_q    <= mode;
        end
    end

    assign f       = f_q;
    assign ch      = ch_q;
    assign f_valid = (state_q == ST_FULL);
    assign wrap    = wrap_q;
    assign sel_err = sel_err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomised bench for mux_scan_n: two instances (N=8/W=4 and N=5/W=8)
// compared each cycle against a behavioural reference model.
module tb_mux_scan_n;

    localparam int unsigned NA = 8;
    localparam int unsigned WA = 4;
    localparam int unsigned NB = 5;
    localparam int unsigned WB = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [7:0]       chan [2][8];
    logic [NA*WA-1:0] w_a;
    logic [NB*WB-1:0] w_b;
    logic [2:0]       s_v [2];
    logic             mode_v [2];
    logic             en_v [2];
    logic             rdy_v [2];

    logic [3:0] f_a;
    logic [7:0] f_b;
    logic [2:0] ch_a, ch_b;
    logic       fv_a, fv_b, wr_a, wr_b, er_a, er_b;

    int total = 0;
    int bad   = 0;

    // Reference model state (value visible on the outputs after the last edge)
    bit         m_valid [2];
    logic [7:0] m_f [2];
    int         m_ch [2];
    bit         m_wrap [2];
    bit         m_err [2];
    int         m_ptr [2];
    bit         m_prev [2];
    int         nch [2] = '{8, 5};
    logic [7:0] msk [2] = '{8'h0F, 8'hFF};

    always_comb begin
        for (int k = 0; k < NA; k++) w_a[k*WA +: WA] = chan[0][k][WA-1:0];
        for (int j = 0; j < NB; j++) w_b[j*WB +: WB] = chan[1][j];
    end

    mux_scan_n #(.N(NA), .W(WA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .w(w_a), .s(s_v[0]), .mode(mode_v[0]),
        .en(en_v[0]), .f(f_a), .ch(ch_a), .f_valid(fv_a), .f_ready(rdy_v[0]),
        .wrap(wr_a), .sel_err(er_a)
    );

    mux_scan_n #(.N(NB), .W(WB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .w(w_b), .s(s_v[1]), .mode(mode_v[1]),
        .en(en_v[1]), .f(f_b), .ch(ch_b), .f_valid(fv_b), .f_ready(rdy_v[1]),
        .wrap(wr_b), .sel_err(er_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_valid[i] = 0; m_f[i] = '0; m_ch[i] = 0; m_wrap[i] = 0;
            m_err[i] = 0; m_ptr[i] = 0; m_prev[i] = 0;
        end
    endtask

    // One clock of behaviour for instance i from the currently driven inputs.
    task automatic model_update(input int i);
        bit load;
        int p;
        load = en_v[i] && (!m_valid[i] || rdy_v[i]);
        p = (mode_v[i] && !m_prev[i]) ? 0 : m_ptr[i];
        if (load) begin
            m_valid[i] = 1;
            if (mode_v[i]) begin
                m_ch[i]   = p;
                m_f[i]    = chan[i][p] & msk[i];
                m_wrap[i] = (p == nch[i] - 1);
                m_ptr[i]  = (p + 1) % nch[i];
            end else begin
                m_ch[i]   = int'(s_v[i]);
                m_wrap[i] = 0;
                m_ptr[i]  = p;
                if (int'(s_v[i]) < nch[i]) begin
                    m_f[i]   = chan[i][s_v[i]] & msk[i];
                    m_err[i] = 0;
                end else begin
                    m_f[i]   = '0;
                    m_err[i] = 1;
                end
            end
        end else begin
            m_wrap[i] = 0;
            m_ptr[i]  = p;
            if (m_valid[i] && rdy_v[i]) m_valid[i] = 0;
        end
        m_prev[i] = mode_v[i];
    endtask

    task automatic check_inst(input int i);
        logic [7:0] gf;
        logic [2:0] gc;
        logic       gv, gw, ge;
        if (i == 0) begin
            gf = {4'h0, f_a}; gc = ch_a; gv = fv_a; gw = wr_a; ge = er_a;
        end else begin
            gf = f_b; gc = ch_b; gv = fv_b; gw = wr_b; ge = er_b;
        end
        chk($sformatf("i%0d_valid", i), 32'(gv), 32'(m_valid[i]));
        chk($sformatf("i%0d_f", i),     32'(gf), 32'(m_f[i]));
        chk($sformatf("i%0d_ch", i),    32'(gc), 32'(m_ch[i]));
        chk($sformatf("i%0d_wrap", i),  32'(gw), 32'(m_wrap[i]));
        chk($sformatf("i%0d_err", i),   32'(ge), 32'(m_err[i]));
    endtask

    // Inputs are already driven (at a falling edge); advance one clock and check.
    task automatic step();
        model_update(0);
        model_update(1);
        @(negedge clk);
        check_inst(0);
        check_inst(1);
    endtask

    task automatic set_in(input int i, input bit md, input bit e, input bit r, input logic [2:0] sel);
        mode_v[i] = md; en_v[i] = e; rdy_v[i] = r; s_v[i] = sel;
    endtask

    initial begin
        logic [2:0] hold_ch;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 8; k++) chan[i][k] = 8'($urandom);
            set_in(i, 0, 0, 1, 3'd0);
        end
        model_reset();
        repeat (2) @(negedge clk);
        check_inst(0);
        check_inst(1);
        rst_n = 1'b1;

        // Manual select of channel 5
        chan[0][5] = 8'h09;
        set_in(0, 0, 1, 1, 3'd5);
        step();
        chk("t1_f", 32'(f_a), 32'h9);
        chk("t1_ch", 32'(ch_a), 32'd5);
        chk("t1_valid", 32'(fv_a), 32'd1);
        chk("t1_err", 32'(er_a), 32'd0);

        // Back-to-back scan with wrap after channel 7
        for (int k = 0; k < 10; k++) begin
            set_in(0, 1, 1, 1, 3'd0);
            step();
            chk("t2_ch", 32'(ch_a), 32'(k % 8));
            chk("t2_wrap", 32'(wr_a), 32'((k % 8) == 7));
        end

        // Stall with consumer not ready: output and pointer hold
        set_in(0, 1, 1, 1, 3'd0);
        step();
        hold_ch = ch_a;
        chk("t3_pre_ch", 32'(hold_ch), 32'(m_ch[0]));
        for (int k = 0; k < 4; k++) begin
            set_in(0, 1, 1, 0, 3'd0);
            step();
            chk("t3_hold_ch", 32'(ch_a), 32'(m_ch[0]));
            chk("t3_hold_valid", 32'(fv_a), 32'd1);
        end
        set_in(0, 1, 1, 1, 3'd0);
        step();
        chk("t3_resume_ch", 32'(ch_a), 32'((int'(hold_ch) + 1) % 8));

        // Non-power-of-two instance: out-of-range manual select
        set_in(1, 0, 1, 1, 3'd6);
        step();
        chk("t4_f", 32'(f_b), 32'h0);
        chk("t4_ch", 32'(ch_b), 32'd6);
        chk("t4_err", 32'(er_b), 32'd1);
        set_in(1, 0, 1, 1, 3'd2);
        step();
        chk("t4_err_clr", 32'(er_b), 32'd0);
        for (int k = 0; k < 12; k++) begin
            set_in(1, 1, 1, 1, 3'd0);
            step();
            chk("t4_ch_range", 32'(ch_b < 3'd5), 32'd1);
            chk("t4_scan_ch", 32'(ch_b), 32'(k % 5));
        end

        // Leave scan at pointer 6, go manual, come back: sweep restarts at 0
        for (int g = 0; g < 10 && m_ptr[0] != 6; g++) begin
            set_in(0, 1, 1, 1, 3'd0);
            step();
        end
        chk("t5_ptr_reached", 32'(m_ptr[0]), 32'd6);
        for (int k = 0; k < 2; k++) begin
            set_in(0, 0, 0, 1, 3'd1);
            step();
        end
        set_in(0, 1, 1, 1, 3'd0);
        step();
        chk("t5_first_ch", 32'(ch_a), 32'd0);

        // Reset while holding a wrapped sample with consumer stalled
        chan[0][7] = 8'h0A;
        for (int g = 0; g < 10 && !(m_ch[0] == 7 && m_wrap[0]); g++) begin
            set_in(0, 1, 1, 1, 3'd0);
            step();
        end
        chk("t6_pre_wrap", 32'(wr_a), 32'd1);
        set_in(0, 1, 0, 0, 3'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(fv_a), 32'd0);
        chk("t6_rst_f", 32'(f_a), 32'd0);
        chk("t6_rst_ch", 32'(ch_a), 32'd0);
        chk("t6_rst_wrap", 32'(wr_a), 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        set_in(0, 1, 1, 1, 3'd0);
        step();
        chk("t6_after_ch", 32'(ch_a), 32'd0);

        // Random traffic on both instances
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < 2; i++) begin
                en_v[i]  = ($urandom_range(0, 9) < 7);
                rdy_v[i] = ($urandom_range(0, 9) < 7);
                if ($urandom_range(0, 9) == 0) mode_v[i] = ~mode_v[i];
                s_v[i] = 3'($urandom_range(0, 7));
                if ($urandom_range(0, 3) == 0) chan[i][$urandom_range(0, 7)] = 8'($urandom);
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
